counter32_ctrl: RTL and testbench

Run/pause/step/clear sequencer for the 32-bit LED counter. It turns raw push-button and switch inputs into clean single-cycle command pulses and a direction level for the counter. It also generates the byte-select that picks which byte of the count drives `led[7:0]`. It sits between the board I/O and the counter datapath at the top level.

---
 rtl/counter32_ctrl.sv | 148 ++++++++++++++
 tb/tb_counter32_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/counter32_ctrl.sv
// counter32_ctrl: turns raw buttons/switches into clean run/step/clear command
// pulses, a count direction level and an auto-scanning LED byte select.
`default_nettype none

module counter32_ctrl #(
  parameter int PRESCALE = 4,
  parameter int SCAN_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_btn,
  input  logic       step_btn,
  input  logic       clr_btn,
  input  logic       sw1,
  input  logic       sw0,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       cnt_up,
  output logic [1:0] byte_sel,
  output logic [1:0] state
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] c_PRE_MAX  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] c_SCAN_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_CLEAR = 2'b11
  } state_t;

  // Bit order of the synchronizer vectors: {sw0, sw1, clr, step, run}
  logic [4:0]    w_async;
  logic [4:0]    r_s1;
  logic [4:0]    r_s2;
  logic [2:0]    r_hist;
  logic [2:0]    w_edge;
  logic          w_run_evt;
  logic          w_step_evt;
  logic          w_clr_evt;

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_next;
  logic          w_presc_tc;
  logic          w_en_d;
  logic          w_clr_d;
  logic          r_en;
  logic          r_clr;
  logic          r_up;
  logic [SW-1:0] r_div;
  logic          w_div_tc;
  logic [1:0]    r_bsel;

  assign w_async    = {sw0, sw1, clr_btn, step_btn, run_btn};
  assign w_edge     = r_s2[2:0] & ~r_hist;
  assign w_run_evt  = w_edge[0];
  assign w_step_evt = w_edge[1];
  assign w_clr_evt  = w_edge[2];
  assign w_presc_tc = (r_presc == c_PRE_MAX);
  assign w_div_tc   = (r_div == c_SCAN_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_hist <= '0;
    end else begin
      r_s1   <= w_async;
      r_s2   <= r_s1;
      r_hist <= r_s2[2:0];
    end
  end

  // Clear beats run beats step; a terminal count is dropped when RUN is left.
  always_comb begin
    w_next  = r_state;
    w_en_d  = 1'b0;
    w_clr_d = 1'b0;
    if (w_clr_evt) begin
      w_next = S_CLEAR;
    end else begin
      case (r_state)
        S_CLEAR: w_next = S_IDLE;
        S_IDLE:  if (w_run_evt) w_next = S_RUN;
        S_RUN: begin
          if (w_run_evt) w_next = S_PAUSE;
          else           w_en_d = w_presc_tc;
        end
        S_PAUSE: begin
          if (w_run_evt)       w_next = S_RUN;
          else if (w_step_evt) w_en_d = 1'b1;
        end
        default: w_next = S_IDLE;
      endcase
    end
    w_clr_d = (w_next == S_CLEAR);
  end

  always_comb begin
    w_presc_next = '0;
    if (r_state == S_RUN && w_next == S_RUN)
      w_presc_next = w_presc_tc ? '0 : r_presc + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_en    <= 1'b0;
      r_clr   <= 1'b0;
      r_up    <= 1'b1;
    end else begin
      r_state <= w_next;
      r_presc <= w_presc_next;
      r_en    <= w_en_d;
      r_clr   <= w_clr_d;
      r_up    <= ~r_s2[3];
    end
  end

  // Scan divider free-runs so the scan phase is independent of the enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div  <= '0;
      r_bsel <= 2'b00;
    end else begin
      r_div <= w_div_tc ? '0 : r_div + 1'b1;
      if (!r_s2[4])
        r_bsel <= 2'b00;
      else if (w_div_tc)
        r_bsel <= r_bsel + 2'b01;
    end
  end

  assign cnt_en   = r_en;
  assign cnt_clr  = r_clr;
  assign cnt_up   = r_up;
  assign byte_sel = r_bsel;
  assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_counter32_ctrl.sv
// tb_counter32_ctrl: directed plus random stimulus checked every cycle against
// a delay-line / cycle-age reference model of the sequencer.
`default_nettype none

module tb_counter32_ctrl;

  localparam int P = 4;
  localparam int S = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_btn = 1'b0;
  logic       step_btn = 1'b0;
  logic       clr_btn = 1'b0;
  logic       sw1 = 1'b0;
  logic       sw0 = 1'b0;
  logic       cnt_en;
  logic       cnt_clr;
  logic       cnt_up;
  logic [1:0] byte_sel;
  logic [1:0] state;

  counter32_ctrl #(.PRESCALE(P), .SCAN_DIV(S)) dut (
    .clk(clk), .rst(rst), .run_btn(run_btn), .step_btn(step_btn),
    .clr_btn(clr_btn), .sw1(sw1), .sw0(sw0), .cnt_en(cnt_en),
    .cnt_clr(cnt_clr), .cnt_up(cnt_up), .byte_sel(byte_sel), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: bit0 = input at previous edge, bit1 = two edges ago, bit2 = three.
  int         n;
  logic [2:0] hr, hs, hc, h1, h0;
  int         ms;
  int         age;
  logic       m_en, m_clr, m_up;
  logic [1:0] m_bs;
  int         en_seen;
  int         clr_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; hr = '0; hs = '0; hc = '0; h1 = '0; h0 = '0;
    ms = 0; age = 0; m_en = 1'b0; m_clr = 1'b0; m_up = 1'b1; m_bs = 2'b00;
  endtask

  task automatic model_edge();
    logic er, es, ec;
    int   ns;
    n++;
    er = hr[1] & ~hr[2];
    es = hs[1] & ~hs[2];
    ec = hc[1] & ~hc[2];
    m_en = 1'b0;
    ns = ms;
    if (ec) ns = 3;
    else begin
      case (ms)
        3: ns = 0;
        0: if (er) ns = 1;
        1: if (er) ns = 2;
           else begin
             age++;
             m_en = ((age % P) == 0);
           end
        default: if (er) ns = 1; else if (es) m_en = 1'b1;
      endcase
    end
    if (ns == 1 && ms != 1) age = 0;
    m_clr = (ns == 3);
    ms = ns;
    m_up = ~h1[1];
    if (!h0[1]) m_bs = 2'b00;
    else if (((n - 1) % S) == S - 1) m_bs = m_bs + 2'b01;
    hr = {hr[1:0], run_btn};
    hs = {hs[1:0], step_btn};
    hc = {hc[1:0], clr_btn};
    h1 = {h1[1:0], sw1};
    h0 = {h0[1:0], sw0};
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
    chk("cnt_en", 32'(cnt_en), 32'(m_en));
    chk("cnt_clr", 32'(cnt_clr), 32'(m_clr));
    chk("cnt_up", 32'(cnt_up), 32'(m_up));
    chk("byte_sel", 32'(byte_sel), 32'(m_bs));
    chk("state", 32'(state), 32'(ms));
    en_seen  += int'(cnt_en);
    clr_seen += int'(cnt_clr);
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;
    cycles(10);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_cnt_up", 32'(cnt_up), 32'd1);

    rst = 1'b1;
    en_seen = 0;
    cycles(50);
    chk("idle_no_en", 32'(en_seen), 32'd0);
    chk("idle_state", 32'(state), 32'd0);

    run_btn = 1'b1; cyc(); run_btn = 1'b0; cyc(); cyc();
    chk("run_entry", 32'(state), 32'd1);
    cycles(5);
    en_seen = 0;
    cycles(40);
    chk("run_cadence_10_of_40", 32'(en_seen), 32'd10);

    run_btn = 1'b1; cyc(); run_btn = 1'b0; cyc(); cyc();
    chk("pause_entry", 32'(state), 32'd2);
    en_seen = 0;
    cycles(20);
    chk("pause_no_en", 32'(en_seen), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step_btn = 1'b1; cyc(); step_btn = 1'b0; cycles(4);
    end
    chk("three_steps", 32'(en_seen), 32'd3);
    en_seen = 0;
    step_btn = 1'b1; cycles(20); step_btn = 1'b0; cycles(4);
    chk("long_step_one_pulse", 32'(en_seen), 32'd1);

    run_btn = 1'b1; cyc(); run_btn = 1'b0; cycles(8);
    chk("rerun", 32'(state), 32'd1);
    clr_seen = 0;
    run_btn = 1'b1; clr_btn = 1'b1; cyc();
    run_btn = 1'b0; clr_btn = 1'b0; cycles(4);
    chk("clear_one_pulse", 32'(clr_seen), 32'd1);
    chk("clear_to_idle", 32'(state), 32'd0);

    sw0 = 1'b1; cycles(40);
    sw0 = 1'b0; cycles(3);
    chk("scan_off_bsel0", 32'(byte_sel), 32'd0);
    sw1 = 1'b1; cycles(3);
    chk("sw1_down", 32'(cnt_up), 32'd0);
    sw1 = 1'b0; cycles(3);

    for (int i = 0; i < 1500; i++) begin
      run_btn  = ($urandom_range(0, 11) == 0);
      step_btn = ($urandom_range(0, 5) == 0);
      clr_btn  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) sw1 = ~sw1;
      if ($urandom_range(0, 29) == 0) sw0 = ~sw0;
      cyc();
    end

    run_btn = 1'b0; step_btn = 1'b0; sw1 = 1'b0; sw0 = 1'b1;
    clr_btn = 1'b1; cyc(); clr_btn = 1'b0; cycles(4);
    run_btn = 1'b1; cyc(); run_btn = 1'b0; cycles(10);
    chk("pre_reset_run", 32'(state), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_cnt_en", 32'(cnt_en), 32'd0);
    chk("async_rst_cnt_clr", 32'(cnt_clr), 32'd0);
    chk("async_rst_cnt_up", 32'(cnt_up), 32'd1);
    chk("async_rst_byte_sel", 32'(byte_sel), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    cycles(3);
    rst = 1'b1;
    en_seen = 0;
    cycles(30);
    chk("no_resume_after_rst", 32'(en_seen), 32'd0);
    chk("idle_after_rst", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
